// File: rtl/swpd_axil_sequencer.sv
// AXI4-Lite master that runs a complete SWPD transfer: optional enable write,
// SEND write, CTRL polling and RECEIVE read, returning the reply on a valid/ready port.
module swpd_axil_sequencer #(
    parameter int C_M_AXI_ADDR_WIDTH = 4,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int POLL_GAP           = 4,
    parameter int POLL_MAX           = 1024
) (
    input  logic                              M_AXI_ACLK,
    input  logic                              M_AXI_ARESET,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic [7:0]                        cmd_send_data,
    input  logic [1:0]                        cmd_reply_len,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [13:0]                       rsp_data,
    output logic                              rsp_xfer_error,
    output logic                              rsp_timeout,
    output logic                              rsp_bus_error,
    output logic                              busy
);

    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int DW = C_M_AXI_DATA_WIDTH;
    localparam int SW = C_M_AXI_DATA_WIDTH / 8;

    localparam logic [AW-1:0] ADDR_CTRL    = AW'(4'h0);
    localparam logic [AW-1:0] ADDR_SEND    = AW'(4'h4);
    localparam logic [AW-1:0] ADDR_RECEIVE = AW'(4'h8);

    typedef enum logic [3:0] {
        S_IDLE, S_EN_W, S_EN_B, S_SEND_W, S_SEND_B,
        S_POLL_AR, S_POLL_R, S_GAP, S_DATA_AR, S_DATA_R, S_RESP
    } state_t;

    state_t          state_reg, state_next;
    logic            enabled_reg, enabled_next;
    logic [7:0]      send_data_reg, send_data_next;
    logic [1:0]      reply_len_reg, reply_len_next;
    logic            aw_valid_reg, aw_valid_next;
    logic            w_valid_reg, w_valid_next;
    logic            aw_done_reg, aw_done_next;
    logic            w_done_reg, w_done_next;
    logic [AW-1:0]   awaddr_reg, awaddr_next;
    logic [DW-1:0]   wdata_reg, wdata_next;
    logic [SW-1:0]   wstrb_reg, wstrb_next;
    logic            ar_valid_reg, ar_valid_next;
    logic [AW-1:0]   araddr_reg, araddr_next;
    logic [15:0]     poll_cnt_reg, poll_cnt_next;
    logic [15:0]     gap_cnt_reg, gap_cnt_next;
    logic [13:0]     rsp_data_reg, rsp_data_next;
    logic            xfer_err_reg, xfer_err_next;
    logic            timeout_reg, timeout_next;
    logic            bus_err_reg, bus_err_next;

    logic aw_hs, w_hs, ar_hs, aw_fin, w_fin, bresp_ok, rresp_ok;
    logic unused_rdata;

    assign aw_hs    = aw_valid_reg && M_AXI_AWREADY;
    assign w_hs     = w_valid_reg && M_AXI_WREADY;
    assign ar_hs    = ar_valid_reg && M_AXI_ARREADY;
    assign aw_fin   = aw_done_reg || aw_hs;
    assign w_fin    = w_done_reg || w_hs;
    assign bresp_ok = (M_AXI_BRESP == 2'b00);
    assign rresp_ok = (M_AXI_RRESP == 2'b00);
    assign unused_rdata = ^M_AXI_RDATA[DW-1:14];

    always_comb begin
        state_next     = state_reg;
        enabled_next   = enabled_reg;
        send_data_next = send_data_reg;
        reply_len_next = reply_len_reg;
        // Each VALID drops independently right after its own handshake.
        aw_valid_next  = aw_valid_reg && !M_AXI_AWREADY;
        w_valid_next   = w_valid_reg && !M_AXI_WREADY;
        aw_done_next   = aw_done_reg || aw_hs;
        w_done_next    = w_done_reg || w_hs;
        awaddr_next    = awaddr_reg;
        wdata_next     = wdata_reg;
        wstrb_next     = wstrb_reg;
        ar_valid_next  = ar_valid_reg && !M_AXI_ARREADY;
        araddr_next    = araddr_reg;
        poll_cnt_next  = poll_cnt_reg;
        gap_cnt_next   = gap_cnt_reg;
        rsp_data_next  = rsp_data_reg;
        xfer_err_next  = xfer_err_reg;
        timeout_next   = timeout_reg;
        bus_err_next   = bus_err_reg;

        case (state_reg)
            S_IDLE: begin
                if (cmd_valid) begin
                    send_data_next = cmd_send_data;
                    reply_len_next = cmd_reply_len;
                    xfer_err_next  = 1'b0;
                    timeout_next   = 1'b0;
                    bus_err_next   = 1'b0;
                    aw_valid_next  = 1'b1;
                    w_valid_next   = 1'b1;
                    aw_done_next   = 1'b0;
                    w_done_next    = 1'b0;
                    if (!enabled_reg) begin
                        state_next  = S_EN_W;
                        awaddr_next = ADDR_CTRL;
                        wdata_next  = DW'(32'h1);
                        wstrb_next  = SW'(4'b0001);
                    end else begin
                        state_next  = S_SEND_W;
                        awaddr_next = ADDR_SEND;
                        wdata_next  = DW'({16'h0, cmd_send_data, 6'h0, cmd_reply_len});
                        wstrb_next  = SW'(4'b0011);
                    end
                end
            end
            S_EN_W: if (aw_fin && w_fin) state_next = S_EN_B;
            S_EN_B: begin
                if (M_AXI_BVALID) begin
                    if (bresp_ok) begin
                        enabled_next  = 1'b1;
                        state_next    = S_SEND_W;
                        aw_valid_next = 1'b1;
                        w_valid_next  = 1'b1;
                        aw_done_next  = 1'b0;
                        w_done_next   = 1'b0;
                        awaddr_next   = ADDR_SEND;
                        wdata_next    = DW'({16'h0, send_data_reg, 6'h0, reply_len_reg});
                        wstrb_next    = SW'(4'b0011);
                    end else begin
                        bus_err_next  = 1'b1;
                        rsp_data_next = 14'h0;
                        state_next    = S_RESP;
                    end
                end
            end
            S_SEND_W: if (aw_fin && w_fin) state_next = S_SEND_B;
            S_SEND_B: begin
                if (M_AXI_BVALID) begin
                    poll_cnt_next = 16'h0;
                    if (bresp_ok) begin
                        state_next    = S_POLL_AR;
                        ar_valid_next = 1'b1;
                        araddr_next   = ADDR_CTRL;
                    end else begin
                        bus_err_next  = 1'b1;
                        rsp_data_next = 14'h0;
                        state_next    = S_RESP;
                    end
                end
            end
            S_POLL_AR: if (ar_hs) state_next = S_POLL_R;
            S_POLL_R: begin
                if (M_AXI_RVALID) begin
                    poll_cnt_next = poll_cnt_reg + 16'd1;
                    // Done is checked before the poll limit so a last-chance completion still reads data.
                    if (!rresp_ok) begin
                        bus_err_next  = 1'b1;
                        rsp_data_next = 14'h0;
                        state_next    = S_RESP;
                    end else if (M_AXI_RDATA[2]) begin
                        xfer_err_next = M_AXI_RDATA[3];
                        state_next    = S_DATA_AR;
                        ar_valid_next = 1'b1;
                        araddr_next   = ADDR_RECEIVE;
                    end else if (poll_cnt_reg + 16'd1 == 16'(POLL_MAX)) begin
                        timeout_next  = 1'b1;
                        rsp_data_next = 14'h0;
                        state_next    = S_RESP;
                    end else if (POLL_GAP == 0) begin
                        state_next    = S_POLL_AR;
                        ar_valid_next = 1'b1;
                        araddr_next   = ADDR_CTRL;
                    end else begin
                        gap_cnt_next  = 16'h0;
                        state_next    = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt_reg == 16'(POLL_GAP - 1)) begin
                    state_next    = S_POLL_AR;
                    ar_valid_next = 1'b1;
                    araddr_next   = ADDR_CTRL;
                end else begin
                    gap_cnt_next = gap_cnt_reg + 16'd1;
                end
            end
            S_DATA_AR: if (ar_hs) state_next = S_DATA_R;
            S_DATA_R: begin
                if (M_AXI_RVALID) begin
                    rsp_data_next = M_AXI_RDATA[13:0];
                    if (!rresp_ok) bus_err_next = 1'b1;
                    state_next = S_RESP;
                end
            end
            S_RESP: if (rsp_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            state_reg     <= S_IDLE;
            enabled_reg   <= 1'b0;
            send_data_reg <= 8'h0;
            reply_len_reg <= 2'h0;
            aw_valid_reg  <= 1'b0;
            w_valid_reg   <= 1'b0;
            aw_done_reg   <= 1'b0;
            w_done_reg    <= 1'b0;
            awaddr_reg    <= '0;
            wdata_reg     <= '0;
            wstrb_reg     <= '0;
            ar_valid_reg  <= 1'b0;
            araddr_reg    <= '0;
            poll_cnt_reg  <= 16'h0;
            gap_cnt_reg   <= 16'h0;
            rsp_data_reg  <= 14'h0;
            xfer_err_reg  <= 1'b0;
            timeout_reg   <= 1'b0;
            bus_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            enabled_reg   <= enabled_next;
            send_data_reg <= send_data_next;
            reply_len_reg <= reply_len_next;
            aw_valid_reg  <= aw_valid_next;
            w_valid_reg   <= w_valid_next;
            aw_done_reg   <= aw_done_next;
            w_done_reg    <= w_done_next;
            awaddr_reg    <= awaddr_next;
            wdata_reg     <= wdata_next;
            wstrb_reg     <= wstrb_next;
            ar_valid_reg  <= ar_valid_next;
            araddr_reg    <= araddr_next;
            poll_cnt_reg  <= poll_cnt_next;
            gap_cnt_reg   <= gap_cnt_next;
            rsp_data_reg  <= rsp_data_next;
            xfer_err_reg  <= xfer_err_next;
            timeout_reg   <= timeout_next;
            bus_err_reg   <= bus_err_next;
        end
    end

    assign M_AXI_AWADDR   = awaddr_reg;
    assign M_AXI_AWPROT   = 3'b000;
    assign M_AXI_AWVALID  = aw_valid_reg;
    assign M_AXI_WDATA    = wdata_reg;
    assign M_AXI_WSTRB    = wstrb_reg;
    assign M_AXI_WVALID   = w_valid_reg;
    // Write-phase states only exit once both AW and W are done, so BREADY is safe here.
    assign M_AXI_BREADY   = (state_reg == S_EN_B) || (state_reg == S_SEND_B);
    assign M_AXI_ARADDR   = araddr_reg;
    assign M_AXI_ARPROT   = 3'b000;
    assign M_AXI_ARVALID  = ar_valid_reg;
    assign M_AXI_RREADY   = (state_reg == S_POLL_R) || (state_reg == S_DATA_R);
    assign cmd_ready      = (state_reg == S_IDLE);
    assign rsp_valid      = (state_reg == S_RESP);
    assign rsp_data       = rsp_data_reg;
    assign rsp_xfer_error = xfer_err_reg;
    assign rsp_timeout    = timeout_reg;
    assign rsp_bus_error  = bus_err_reg;
    assign busy           = (state_reg != S_IDLE);

endmodule

// File: tb/tb_swpd_axil_sequencer.sv
// Bench for swpd_axil_sequencer: a behavioural AXI-Lite slave logs every transfer,
// and a transaction-level model predicts the log and response for each command.
module tb_swpd_axil_sequencer;
    localparam int PG = 2;
    localparam int PM = 4;

    typedef struct packed {
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } txn_t;

    logic clk = 1'b0;
    logic srst;
    always #5 clk = ~clk;

    logic [3:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        arvalid, rvalid, rready;
    logic        arready = 1'b1;
    logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready;
    logic [7:0]  cmd_send_data;
    logic [1:0]  cmd_reply_len;
    logic [13:0] rsp_data;
    logic        rsp_xfer_error, rsp_timeout, rsp_bus_error, busy;

    swpd_axil_sequencer #(.C_M_AXI_ADDR_WIDTH(4), .C_M_AXI_DATA_WIDTH(32),
                          .POLL_GAP(PG), .POLL_MAX(PM)) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESET(srst),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid),
        .M_AXI_AWREADY(awready), .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb),
        .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready), .M_AXI_BRESP(bresp),
        .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready), .M_AXI_ARADDR(araddr),
        .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid),
        .M_AXI_RREADY(rready), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_send_data(cmd_send_data), .cmd_reply_len(cmd_reply_len),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_xfer_error(rsp_xfer_error), .rsp_timeout(rsp_timeout),
        .rsp_bus_error(rsp_bus_error), .busy(busy)
    );

    // Slave configuration, written only by the stimulus block.
    int          aw_delay, w_delay, r_delay, done_poll;
    bit          b_early, xerr, data_rerr;
    logic [1:0]  bresp_en, bresp_send;
    logic [13:0] recv;

    // Slave bookkeeping, written only by the slave process.
    txn_t        log_q[$];
    int          aw_cnt, w_cnt, r_cnt, poll_no, cyc, last_poll, proto_errs, gap_errs;
    bit          aw_got, w_got, b_issued, r_pending;
    logic [3:0]  wa_addr, r_addr;
    logic [31:0] w_data_cap;
    logic [3:0]  w_strb_cap;
    bit          p_awv, p_aw_hs, p_wv, p_w_hs;
    logic [3:0]  p_awaddr;
    logic [31:0] p_wdata;
    logic [3:0]  p_wstrb;

    function automatic void log_write(logic [3:0] a, logic [31:0] d, logic [3:0] s);
        log_q.push_back('{wr: 1'b1, addr: a, data: d, strb: s});
        if (a == 4'h4) begin
            poll_no   = 0;
            last_poll = -1;
        end
    endfunction

    always @(posedge clk) begin
        logic [31:0] rnd;
        bit          done;
        cyc++;
        if (srst) begin
            awready <= 1'b0; wready <= 1'b0; bvalid <= 1'b0; bresp <= 2'b00;
            rvalid <= 1'b0; rdata <= 32'h0; rresp <= 2'b00;
            aw_got = 0; w_got = 0; b_issued = 0; r_pending = 0;
            aw_cnt = 0; w_cnt = 0; r_cnt = 0; last_poll = -1;
            p_awv = 0; p_aw_hs = 0; p_wv = 0; p_w_hs = 0;
        end else begin
            if (p_awv && !p_aw_hs && (!awvalid || awaddr !== p_awaddr)) proto_errs++;
            if (p_wv && !p_w_hs && (!wvalid || wdata !== p_wdata || wstrb !== p_wstrb)) proto_errs++;
            if (p_aw_hs && awvalid) proto_errs++;
            if (p_w_hs && wvalid) proto_errs++;
            if (bready && !(aw_got && w_got)) proto_errs++;
            if (arvalid && (rvalid || r_pending)) proto_errs++;
            p_awv = awvalid; p_aw_hs = awvalid && awready; p_awaddr = awaddr;
            p_wv = wvalid; p_w_hs = wvalid && wready; p_wdata = wdata; p_wstrb = wstrb;

            if (bvalid && bready) begin
                bvalid <= 1'b0;
                aw_got = 0; w_got = 0; b_issued = 0;
            end
            if (awvalid && awready) begin
                aw_got = 1; wa_addr = awaddr; awready <= 1'b0;
            end else if (awvalid) begin
                if (aw_cnt >= aw_delay) awready <= 1'b1;
                aw_cnt++;
            end else begin
                awready <= (aw_delay == 0); aw_cnt = 0;
            end
            if (wvalid && wready) begin
                w_got = 1; w_data_cap = wdata; w_strb_cap = wstrb; wready <= 1'b0;
            end else if (wvalid) begin
                if (w_cnt >= w_delay) begin
                    wready <= 1'b1;
                    // Raise BVALID in the very cycle WREADY goes high.
                    if (b_early && aw_got && !b_issued) begin
                        bvalid <= 1'b1;
                        bresp  <= (wa_addr == 4'h0) ? bresp_en : bresp_send;
                        b_issued = 1;
                        log_write(wa_addr, wdata, wstrb);
                    end
                end
                w_cnt++;
            end else begin
                wready <= (w_delay == 0); w_cnt = 0;
            end
            if (aw_got && w_got && !b_issued) begin
                bvalid <= 1'b1;
                bresp  <= (wa_addr == 4'h0) ? bresp_en : bresp_send;
                b_issued = 1;
                log_write(wa_addr, w_data_cap, w_strb_cap);
            end

            if (arvalid && arready) begin
                r_addr = araddr; r_pending = 1; r_cnt = 0;
                log_q.push_back('{wr: 1'b0, addr: araddr, data: 32'h0, strb: 4'h0});
                if (araddr == 4'h0 && last_poll >= 0 && (cyc - last_poll) != PG + 1) gap_errs++;
            end
            if (rvalid && rready) begin
                rvalid <= 1'b0;
                if (r_addr == 4'h0) last_poll = cyc;
            end else if (r_pending) begin
                if (r_cnt >= r_delay) begin
                    rvalid <= 1'b1; r_pending = 0;
                    rnd = $urandom();
                    if (r_addr == 4'h0) begin
                        poll_no++;
                        done = (done_poll != 0) && (poll_no >= done_poll);
                        rdata <= {rnd[31:4], done ? xerr : rnd[3], done, rnd[1:0]};
                        rresp <= 2'b00;
                    end else begin
                        rdata <= {rnd[31:14], recv};
                        rresp <= data_rerr ? 2'b10 : 2'b00;
                    end
                end
                r_cnt++;
            end
        end
    end

    int tests = 0;
    int fails = 0;
    bit model_en;
    txn_t exp_q[$];
    logic [13:0] exp_data;
    bit exp_xerr, exp_to, exp_bus;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Transaction-level prediction from the register sequence rules.
    task automatic build_expect(input logic [7:0] sd, input logic [1:0] rl);
        int npolls;
        bit done;
        exp_q.delete();
        exp_data = 14'h0; exp_xerr = 0; exp_to = 0; exp_bus = 0;
        if (!model_en) begin
            exp_q.push_back('{1'b1, 4'h0, 32'h1, 4'h1});
            if (bresp_en != 2'b00) begin exp_bus = 1; return; end
            model_en = 1;
        end
        exp_q.push_back('{1'b1, 4'h4, {16'h0, sd, 6'h0, rl}, 4'h3});
        if (bresp_send != 2'b00) begin exp_bus = 1; return; end
        done   = (done_poll >= 1) && (done_poll <= PM);
        npolls = done ? done_poll : PM;
        for (int i = 0; i < npolls; i++) exp_q.push_back('{1'b0, 4'h0, 32'h0, 4'h0});
        if (done) begin
            exp_q.push_back('{1'b0, 4'h8, 32'h0, 4'h0});
            exp_xerr = xerr;
            exp_data = recv;
            exp_bus  = data_rerr;
        end else begin
            exp_to = 1;
        end
    endtask

    task automatic run_cmd(input string name, input logic [7:0] sd, input logic [1:0] rl);
        int base, pe, ge, n, hold, m;
        base = log_q.size(); pe = proto_errs; ge = gap_errs;
        build_expect(sd, rl);
        @(negedge clk);
        check({name, "_cmd_ready"}, cmd_ready, 1'b1);
        cmd_valid = 1; cmd_send_data = sd; cmd_reply_len = rl;
        @(posedge clk); #1;
        cmd_valid = 0;
        @(negedge clk);
        check({name, "_busy"}, {busy, cmd_ready}, 2'b10);
        n = 0;
        while (!rsp_valid && n < 3000) begin @(negedge clk); n++; end
        check({name, "_rsp_seen"}, rsp_valid, 1'b1);
        hold = $urandom_range(0, 3);
        repeat (hold) @(negedge clk);
        check({name, "_rsp_held"}, rsp_valid, 1'b1);
        check({name, "_rsp"}, {rsp_data, rsp_xfer_error, rsp_timeout, rsp_bus_error},
              {exp_data, exp_xerr, exp_to, exp_bus});
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
        @(negedge clk);
        check({name, "_idle"}, {busy, rsp_valid, cmd_ready}, 3'b001);
        check({name, "_ntxn"}, log_q.size() - base, exp_q.size());
        m = (log_q.size() - base < exp_q.size()) ? log_q.size() - base : exp_q.size();
        for (int i = 0; i < m; i++)
            check($sformatf("%s_txn%0d", name, i), log_q[base + i], exp_q[i]);
        check({name, "_protocol"}, proto_errs - pe, 0);
        check({name, "_poll_gap"}, gap_errs - ge, 0);
        $display("[TB] %s: send=%02h len=%0d data=%04h xerr=%0d to=%0d bus=%0d txns=%0d",
                 name, sd, rl, rsp_data, rsp_xfer_error, rsp_timeout, rsp_bus_error, log_q.size() - base);
    endtask

    task automatic default_cfg();
        aw_delay = 0; w_delay = 0; r_delay = 0; b_early = 0;
        done_poll = 3; xerr = 0; data_rerr = 0; recv = 14'h2ABC;
        bresp_en = 2'b00; bresp_send = 2'b00;
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_ctl"}, {awvalid, wvalid, arvalid, bready, rready, rsp_valid, busy, cmd_ready},
              8'b0000_0001);
        check({name, "_addr"}, {awaddr, araddr, wstrb, awprot, arprot}, 18'h0);
        check({name, "_wdata"}, wdata, 32'h0);
        check({name, "_rsp"}, {rsp_data, rsp_xfer_error, rsp_timeout, rsp_bus_error}, 17'h0);
    endtask

    initial begin
        int n;
        srst = 1; cmd_valid = 0; rsp_ready = 0; cmd_send_data = 0; cmd_reply_len = 0;
        proto_errs = 0; gap_errs = 0; poll_no = 0; cyc = 0;
        default_cfg();
        model_en = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        srst = 0;

        run_cmd("basic", 8'hA5, 2'd2);
        default_cfg();
        run_cmd("second", 8'h3C, 2'd0);
        default_cfg(); w_delay = 5; b_early = 1;
        run_cmd("b_same_cycle", 8'h5A, 2'd1);
        default_cfg(); done_poll = 0;
        run_cmd("timeout", 8'h11, 2'd3);
        default_cfg(); done_poll = PM; xerr = 1; recv = 14'h1234;
        run_cmd("done_err_last", 8'h22, 2'd1);
        default_cfg(); bresp_send = 2'b10;
        run_cmd("send_slverr", 8'h33, 2'd2);

        for (int it = 0; it < 12; it++) begin
            aw_delay   = $urandom_range(0, 3);
            w_delay    = $urandom_range(0, 3);
            r_delay    = $urandom_range(0, 2);
            b_early    = 1'($urandom_range(0, 1));
            done_poll  = $urandom_range(0, 5);
            xerr       = 1'($urandom_range(0, 1));
            data_rerr  = ($urandom_range(0, 7) == 0);
            recv       = 14'($urandom());
            bresp_send = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00;
            bresp_en   = 2'b00;
            run_cmd($sformatf("rand%0d", it), 8'($urandom()), 2'($urandom()));
        end

        // Abort in the middle of a poll read.
        default_cfg(); done_poll = 0; r_delay = 20;
        @(negedge clk);
        cmd_valid = 1; cmd_send_data = 8'h77; cmd_reply_len = 2'd1;
        @(posedge clk); #1;
        cmd_valid = 0;
        n = 0;
        while (!rready && n < 500) begin @(negedge clk); n++; end
        check("abort_reach_poll_r", rready, 1'b1);
        srst = 1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("abort");
        srst = 0;
        model_en = 0;
        $display("[TB] abort: reset applied during poll read");

        default_cfg(); recv = 14'h0F0F; done_poll = 1;
        run_cmd("after_abort", 8'hC3, 2'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/swpd_axil_sequencer.md
Name: swpd_axil_sequencer

Overview:
- AXI4-Lite master (initiator) that drives the SWPD control register slave on behalf of the streaming logic.
- Accepts one transfer command (send byte + reply length) and performs the full register sequence: enable write if needed, SEND write, CTRL status poll, RECEIVE read.
- Returns the 14-bit reply plus status flags on a valid/ready response port.
- Removes CPU involvement from SWPD transfers.

Parameters:
- C_M_AXI_ADDR_WIDTH, 4, AXI address width; registers at 0x0 CTRL, 0x4 SEND, 0x8 RECEIVE.
- C_M_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
- POLL_GAP, 4, idle cycles between successive CTRL polls (0 = back-to-back).
- POLL_MAX, 1024, maximum CTRL polls before timeout; range 1..65535.

Ports:
- M_AXI_ACLK in 1: clock.
- M_AXI_ARESET in 1: synchronous, active-high reset.
- M_AXI_AWADDR out C_M_AXI_ADDR_WIDTH: write address.
- M_AXI_AWPROT out 3: tied 3'b000.
- M_AXI_AWVALID out 1; M_AXI_AWREADY in 1: write address handshake.
- M_AXI_WDATA out 32; M_AXI_WSTRB out 4: write data and strobes.
- M_AXI_WVALID out 1; M_AXI_WREADY in 1: write data handshake.
- M_AXI_BRESP in 2; M_AXI_BVALID in 1; M_AXI_BREADY out 1: write response.
- M_AXI_ARADDR out C_M_AXI_ADDR_WIDTH; M_AXI_ARPROT out 3 (tied 0): read address.
- M_AXI_ARVALID out 1; M_AXI_ARREADY in 1: read address handshake.
- M_AXI_RDATA in 32; M_AXI_RRESP in 2; M_AXI_RVALID in 1; M_AXI_RREADY out 1: read data.
- cmd_valid in 1; cmd_ready out 1: command handshake.
- cmd_send_data in 8: byte to send.
- cmd_reply_len in 2: reply length.
- rsp_valid out 1; rsp_ready in 1: response handshake.
- rsp_data out 14: RDATA[13:0] of the RECEIVE read.
- rsp_xfer_error out 1: CTRL bit3 on the final poll.
- rsp_timeout out 1: poll limit reached.
- rsp_bus_error out 1: any non-OKAY BRESP/RRESP.
- busy out 1: high in every state except IDLE.

Behaviour:
- Reset values: all VALID/READY outputs 0, addresses/WDATA/WSTRB 0, rsp_* 0, enabled flag 0, state IDLE.
- Reset mid-transaction aborts immediately; no handshake completion is required afterwards.
- cmd_ready = (state==IDLE). The command is accepted on cmd_valid&&cmd_ready, and send_data/reply_len are latched.
- FSM transitions:
  - IDLE -> EN_W if the enabled flag is 0, otherwise SEND_W.
  - EN_W: AW 0x0, WDATA 0x1, WSTRB 0001.
  - EN_B: on BVALID: OKAY sets the enabled flag -> SEND_W; error -> RESP with bus_error.
  - SEND_W: AW 0x4, WDATA {16'h0, send_data, 6'h0, reply_len}, WSTRB 0011.
  - SEND_B: OKAY -> POLL_AR, error -> RESP.
  - POLL_AR: AR 0x0.
  - POLL_R: on RVALID:
    - RRESP error -> RESP.
    - RDATA[2]=1 -> DATA_AR, capturing RDATA[3].
    - Poll count == POLL_MAX -> RESP with timeout.
    - Otherwise -> GAP.
  - GAP: wait POLL_GAP cycles -> POLL_AR.
  - DATA_AR: AR 0x8.
  - DATA_R: capture RDATA[13:0]; RRESP error sets bus_error; -> RESP.
  - RESP: rsp_valid=1 until rsp_ready; -> IDLE. Flags are cleared on command accept.
- Write channel rules:
  - AWVALID and WVALID rise together on state entry and each is held with its payload stable until its own READY.
  - Each VALID drops the cycle after its own handshake, independently; READY may precede VALID.
  - BREADY=1 only in *_B states, and only after both AW and W have handshaken.
  - A BVALID arriving in the same cycle as the last W handshake is legal and must not be lost.
- Read channel rules:
  - ARVALID is held until ARREADY.
  - RREADY=1 in *_R states.
  - An RVALID arriving in the cycle after the AR handshake is accepted.
- No outstanding transactions: at most one AXI transaction is in flight.
- Poll counter: 16 bits, cleared on SEND_B exit, incremented per completed poll.
- Timeout check: against POLL_MAX after the increment; POLL_MAX=1 means a single poll only.
- The done bit has priority over timeout when both occur on the same poll.
- rsp_data holds its value until the next RESP; it is 0 when data was never read.

Test Plan:
- Reset, AWREADY/WREADY/ARREADY=1, slave sets done on poll 3, RECEIVE=0x2ABC, cmd 0xA5/len2:
  - Expect EN write (0x0, WDATA 1, WSTRB 1), then SEND write (0x4, WDATA 0x0000A502, WSTRB 3).
  - Expect 3 polls of 0x0 spaced by POLL_GAP, then a read of 0x8.
  - Expect rsp_data=0x2ABC and all flags 0.
- Second cmd 0x3C:
  - No EN write.
  - First AXI transaction is SEND at 0x4 with WDATA 0x00003C00 for reply_len=0.
- WREADY delayed 5 cycles after AWREADY, then BVALID in the same cycle as the W handshake:
  - AWVALID drops after its handshake while WVALID is held; BVALID is consumed.
  - No hang; the sequence completes.
- POLL_MAX=4, done never set: exactly 4 polls, no 0x8 read, rsp_timeout=1.
- Final poll returns 0xC (done+error): rsp_xfer_error=1, RECEIVE still read.
- BRESP=2'b10 on SEND: rsp_bus_error=1, no polls.
- Assert reset during POLL_R: all outputs return to reset values the next cycle.
